// File: rtl/scan_display_controller_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package scan_display_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int DWELL_DEF      = 4;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_display.sv
// Nibble to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module seven_display (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Hex glyph lookup
  always_comb begin
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/scan_display_controller.sv
// Time-multiplexed seven-segment scanner with dwell/guard phases, double-buffered
// display value committed on frame boundaries, and leading-zero blanking.
module scan_display_controller
  import scan_display_controller_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DWELL      = DWELL_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    en,
  input  logic                    lzb,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam int CNT_W = width_of(DWELL);
  localparam int VAL_W = 4 * NUM_DIGITS;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VAL_W-1:0]        active_q, active_d;
  logic [VAL_W-1:0]        shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wrap;
  logic                    dark;
  logic [3:0]              nib_sel;

  // True when digit i is above digit 0 and every nibble from i upward is zero.
  function automatic logic leading_zero(input logic [VAL_W-1:0] v,
                                        input logic [IDX_W-1:0] i);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) >= i && v[4*k +: 4] != 4'h0) all_zero = 1'b0;
    end
    return (i != '0) && all_zero;
  endfunction

  // Next-state: scan sequencing, frame commit, load capture and digit enables
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    wrap         = 1'b0;
    dark         = 1'b0;
    an_d         = '1;

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_SCAN: begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GUARD: begin
          state_d = ST_SCAN;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Frame boundary: old shadow is committed before any same-cycle load lands
    if (wrap) begin
      frame_done_d = 1'b1;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (load) begin
      if (state_q == ST_IDLE) begin
        active_d = value_in;
      end else begin
        shadow_d  = value_in;
        pending_d = 1'b1;
      end
    end

    // Enables are computed from next-state values so they line up with seg
    dark = lzb && leading_zero(active_d, idx_d);
    if (state_d == ST_SCAN && !dark) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) an_d[k] = 1'b0;
      end
    end
  end

  // State and output registers; reset wins over every other input
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
    end
  end

  // Select the nibble of the currently scanned digit
  always_comb begin
    nib_sel = active_q[3:0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) nib_sel = active_q[4*k +: 4];
    end
  end

  seven_display u_dec (
    .nibble_i (nib_sel),
    .seg_o    (seg)
  );

  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_controller.sv
// Bench for scan_display_controller: per-cycle scoreboard from a behavioural
// reference plus constant tables and directed sequences for corner cases.
module tb_scan_display_controller;

  localparam int ND = 4;
  localparam int DW = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick  = 1'b0;
  logic        en    = 1'b0;
  logic        lzb   = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  scan_display_controller #(.NUM_DIGITS(ND), .DWELL(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .en         (en),
    .lzb        (lzb),
    .load       (load),
    .value_in   (value_in),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tcnt    = 0;

  // Reference model state: 0 idle, 1 scan, 2 guard
  int          m_st = 0;
  int          m_idx = 0;
  int          m_cnt = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_sh  = '0;
  logic        m_pend = 1'b0;
  logic        m_fd   = 1'b0;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
      4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
      4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
      4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; default: r = 7'h0E;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the reference by one clock using the inputs currently driven
  task automatic model_step();
    int          o_st, o_idx;
    logic [15:0] o_sh, upper;
    logic        o_pend;
    exp_t        e;
    o_st = m_st; o_idx = m_idx; o_sh = m_sh; o_pend = m_pend;
    m_fd = 1'b0;
    if (reset) begin
      m_st = 0; m_idx = 0; m_cnt = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
    end else begin
      if (!en) begin
        m_st = 0; m_idx = 0; m_cnt = 0;
      end else if (tick) begin
        if (o_st == 0) begin
          m_st = 1; m_idx = 0; m_cnt = 0;
        end else if (o_st == 1) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == DW) begin m_cnt = 0; m_st = 2; end
        end else begin
          m_st  = 1;
          m_idx = (o_idx + 1) % ND;
          if (m_idx == 0) begin
            m_fd = 1'b1;
            if (o_pend) begin m_act = o_sh; m_pend = 1'b0; end
          end
        end
      end
      if (load) begin
        if (o_st == 0) m_act = value_in;
        else begin m_sh = value_in; m_pend = 1'b1; end
      end
    end
    upper  = m_act >> (4 * m_idx);
    e.an   = 4'hF;
    if (m_st == 1 && !(lzb && m_idx > 0 && upper == 16'h0)) e.an[m_idx] = 1'b0;
    e.seg  = seg_ref(4'(upper));
    e.pend = m_pend;
    e.fd   = m_fd;
    sb_q.push_back(e);
  endtask

  // One clock: predict, clock, compare, then schedule the next scan strobe
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check("sb_an", 32'(an), 32'(e.an));
    check("sb_pending", 32'(pending), 32'(e.pend));
    check("sb_frame_done", 32'(frame_done), 32'(e.fd));
    if (e.an != 4'hF) check("sb_seg", 32'(seg), 32'(e.seg));
    tcnt++;
    tick = (tcnt % 4 == 3);
  endtask

  task automatic tick_cycle();
    logic t;
    for (int k = 0; k < 5; k++) begin
      t = tick;
      cycle();
      if (t) return;
    end
    check("tick_budget", 32'd0, 32'd1);
  endtask

  task automatic run_until_an(input logic [3:0] target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (an === target) return;
      cycle();
    end
    check("wait_an", 32'(an), 32'(target));
  endtask

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] digit;
    logic       fd;
  } vec_t;

  vec_t vecs [13];
  int   lit;
  logic fd_seen;

  initial begin
    // Post-tick display sequence for value 1234, DWELL=2
    vecs[0]  = '{4'b1110, 4'h4, 1'b0};
    vecs[1]  = '{4'b1110, 4'h4, 1'b0};
    vecs[2]  = '{4'b1111, 4'h0, 1'b0};
    vecs[3]  = '{4'b1101, 4'h3, 1'b0};
    vecs[4]  = '{4'b1101, 4'h3, 1'b0};
    vecs[5]  = '{4'b1111, 4'h0, 1'b0};
    vecs[6]  = '{4'b1011, 4'h2, 1'b0};
    vecs[7]  = '{4'b1011, 4'h2, 1'b0};
    vecs[8]  = '{4'b1111, 4'h0, 1'b0};
    vecs[9]  = '{4'b0111, 4'h1, 1'b0};
    vecs[10] = '{4'b0111, 4'h1, 1'b0};
    vecs[11] = '{4'b1111, 4'h0, 1'b0};
    vecs[12] = '{4'b1110, 4'h4, 1'b1};

    // Reset state
    reset = 1'b1;
    cycle(); cycle();
    check("rst_an", 32'(an), 32'hF);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // Load in IDLE goes straight to active, then scan a full frame
    value_in = 16'h1234; load = 1'b1;
    cycle();
    load = 1'b0;
    check("idle_load_pending", 32'(pending), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick_cycle();
      check("tbl_an", 32'(an), 32'(vecs[i].an));
      check("tbl_fd", 32'(frame_done), 32'(vecs[i].fd));
      if (vecs[i].an != 4'hF) check("tbl_seg", 32'(seg), 32'(seg_ref(vecs[i].digit)));
    end

    // Mid-frame load waits for the frame boundary
    run_until_an(4'b1101, 20);
    value_in = 16'h5678; load = 1'b1;
    cycle();
    load = 1'b0;
    check("mid_pending", 32'(pending), 32'd1);
    check("mid_keep_seg", 32'(seg), 32'(seg_ref(4'h3)));
    fd_seen = 1'b0;
    for (int k = 0; k < 60 && !fd_seen; k++) begin
      cycle();
      fd_seen = frame_done;
    end
    check("commit_fd_seen", 32'(fd_seen), 32'd1);
    check("commit_pending", 32'(pending), 32'd0);
    check("commit_an", 32'(an), 32'b1110);
    check("commit_seg", 32'(seg), 32'(seg_ref(4'h8)));

    // Dropping enable during digit 2 blanks at once and restarts at digit 0
    run_until_an(4'b1011, 60);
    en = 1'b0;
    cycle();
    check("en_off_an", 32'(an), 32'hF);
    check("en_off_fd", 32'(frame_done), 32'd0);
    cycle(); cycle(); cycle();
    en = 1'b1;
    run_until_an(4'b1110, 8);
    check("en_restart_seg", 32'(seg), 32'(seg_ref(4'h8)));

    // Load on the wrap cycle: old shadow committed, new one stays pending
    value_in = 16'hAAAA; load = 1'b1;
    cycle();
    load = 1'b0;
    run_until_an(4'b0111, 60);
    run_until_an(4'b1111, 20);
    for (int k = 0; k < 4 && !tick; k++) cycle();
    value_in = 16'hBBBB; load = 1'b1;
    cycle();
    load = 1'b0;
    check("wrap_fd", 32'(frame_done), 32'd1);
    check("wrap_pending", 32'(pending), 32'd1);
    check("wrap_seg", 32'(seg), 32'(seg_ref(4'hA)));
    fd_seen = 1'b0;
    for (int k = 0; k < 60 && !fd_seen; k++) begin
      cycle();
      fd_seen = frame_done;
    end
    check("wrap2_fd_seen", 32'(fd_seen), 32'd1);
    check("wrap2_seg", 32'(seg), 32'(seg_ref(4'hB)));
    check("wrap2_pending", 32'(pending), 32'd0);

    // Leading-zero blanking
    en = 1'b0; cycle();
    lzb = 1'b1; value_in = 16'h0070; load = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1;
    lit = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      lit = lit | int'(~an);
      if (an == 4'b1101) check("lzb_d1_seg", 32'(seg), 32'(seg_ref(4'h7)));
      if (an == 4'b1110) check("lzb_d0_seg", 32'(seg), 32'(seg_ref(4'h0)));
    end
    check("lzb_0070_lit", 32'(lit[3:0]), 32'b0011);
    en = 1'b0; cycle();
    value_in = 16'h0000; load = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1;
    lit = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      lit = lit | int'(~an);
    end
    check("lzb_0000_lit", 32'(lit[3:0]), 32'b0001);

    // Reset during GUARD with a pending shadow discards it
    lzb = 1'b0;
    cycle(); cycle();
    value_in = 16'h9999; load = 1'b1;
    cycle();
    load = 1'b0;
    run_until_an(4'b1111, 20);
    while (m_st != 2) cycle();
    check("guard_pending", 32'(pending), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("grst_an", 32'(an), 32'hF);
    check("grst_pending", 32'(pending), 32'd0);
    check("grst_fd", 32'(frame_done), 32'd0);
    run_until_an(4'b1110, 8);
    check("grst_seg", 32'(seg), 32'(seg_ref(4'h0)));
    for (int k = 0; k < 50; k++) cycle();
    check("grst_no_commit", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_display_controller.md
SCAN_DISPLAY_CONTROLLER -- requirements
Module: scan_display_controller

Interface
REQ-001 Parameter: NUM_DIGITS, 4, number of time-multiplexed seven-segment digits.
REQ-002 Parameter: DWELL, 4, scan ticks each digit stays lit (>=1).
REQ-003 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: tick  input  1  one-cycle scan strobe from the frequency divider.
REQ-006 Port: en  input  1  scan enable; 0 forces all digits dark.
REQ-007 Port: lzb  input  1  leading-zero blanking enable.
REQ-008 Port: load  input  1  one-cycle strobe; captures value_in.
REQ-009 Port: value_in  input  4*NUM_DIGITS  BCD/hex nibbles; digit 0 in bits [3:0].
REQ-010 Port: an  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-011 Port: seg  output  7  segment pattern of the selected nibble.
REQ-012 Port: pending  output  1  shadow value waiting for a frame boundary.
REQ-013 Port: frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-014 States: IDLE (all dark), SCAN (digit idx lit), GUARD (all dark, anti-ghosting).
REQ-015 IDLE -> SCAN on a cycle with en=1 and tick=1; idx=0, dwell count=0.
REQ-016 SCAN: each tick increments the dwell count; the tick at count DWELL-1 -> GUARD, count cleared.
REQ-017 GUARD lasts until the next tick; that tick advances idx to (idx+1) mod NUM_DIGITS and returns to SCAN.
REQ-018 Wrap from NUM_DIGITS-1 to 0 in GUARD: frame_done=1 for exactly that cycle; if pending=1, active<=shadow and pending<=0 in the same cycle.
REQ-019 en=0 in any state: next state IDLE, an all 1 next cycle, idx and count cleared; no frame_done.
REQ-020 Cycles without tick hold state, idx and count.
REQ-021 load in SCAN/GUARD: shadow<=value_in, pending<=1; a second load before commit overwrites shadow (last wins).
REQ-022 load in IDLE: active<=value_in directly next cycle; pending stays 0.
REQ-023 load coincident with frame commit: commit uses old shadow; new value goes to shadow; pending stays 1.
REQ-024 an: registered; in SCAN the bit for idx is 0, all others 1; all 1 in IDLE/GUARD.
REQ-025 lzb=1: digit idx>0 is dark while all active nibbles from idx up to NUM_DIGITS-1 are 0; digit 0 always lit; timing unchanged.
REQ-026 seg: decode of active nibble idx via the existing 7-segment decoder; combinational from registered idx/active, one cycle of decode latency allowed only if an is delayed to match.

Reset
REQ-027 reset=1: state IDLE, idx 0, count 0, active 0, shadow 0, pending 0, frame_done 0, an all 1.
REQ-028 reset has priority over en, tick and load in the same cycle; reset mid-frame discards pending shadow.

Structure
REQ-029 Shared package holds the state encoding (IDLE/SCAN/GUARD), NUM_DIGITS and DWELL defaults.
REQ-030 One sub-module: seven_display (existing nibble-to-segment decoder), instantiated once and shared across digits.

Verification (NUM_DIGITS=4, DWELL=2, tick every 4 clocks)
REQ-031 reset, en=1, value 16'h1234 loaded in IDLE -> an sequence 1110,1111,1101,1111,1011,1111,0111,1111, each phase per REQ-016/017; seg shows 4,3,2,1 respectively.
REQ-032 load 16'h5678 mid-frame -> pending=1 and display keeps 1234 until wrap; frame_done pulses once, pending=0, next frame shows 5678.
REQ-033 lzb=1, value 16'h0070 -> digits 3 and 2 stay dark, digit 1 shows 7, digit 0 shows 0; value 16'h0000 -> only digit 0 lit.
REQ-034 en dropped during SCAN of digit 2 -> an=1111 next cycle, no frame_done; en raised -> scan restarts at digit 0.
REQ-035 load on the wrap cycle with pending shadow 16'hAAAA, value_in 16'hBBBB -> AAAA shown next frame, pending stays 1, BBBB shown the frame after.
REQ-036 reset during GUARD with pending=1 -> all outputs at REQ-027 values next cycle; shadow discarded.
